muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative controller and datapath for the RV32M multiply/divide instructions in the pipelined core.
- Sits beside the ALU in the Execute stage. The decoder raises start for OP-type instructions with funct7 = 0000001.
- Runs a radix-2 shift-add multiply or a restoring divide over XLEN cycles.
- Holds the pipeline through stall until the result is ready. Handles RISC-V divide-by-zero and overflow corner cases in one cycle.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX stage holds a valid M-extension instruction.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B.
- rd_in  in  5  destination register tag.
- flush  in  1  abort the current operation (branch mispredict / trap).
- stall  out  1  freeze IF/ID/EX; combinational.
- busy  out  1  state is CALC or SIGN.
- done  out  1  one-cycle pulse; result and rd_out valid.
- result  out  XLEN  final value.
- rd_out  out  5  tag captured at start.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; counter=0; busy=0; done=0; result=0; rd_out=0; all internal registers=0.
- States: IDLE, CALC, SIGN, DONE.
- Acceptance:
  - start is accepted only in IDLE or DONE.
  - On acceptance, latch funct3, rd_in, |A|, |B| and the sign flags.
  - Signedness: MULH/DIV/REM treat both operands as signed. MULHSU treats only rs1 as signed. The rest are unsigned.
- Special cases, checked at acceptance and sent straight to DONE next cycle (done at T+1):
  - B==0 with DIV/DIVU: result=all ones.
  - B==0 with REM/REMU: result=A.
  - A==0x80000000 and B==0xFFFFFFFF with DIV: result=0x80000000.
  - Same operands with REM: result=0.
- Normal path, with start at cycle T:
  - CALC covers T+1..T+XLEN, counter from 0 to XLEN-1.
  - Multiply: 2*XLEN product register; add multiplicand if LSB of multiplier set, then shift right.
  - Divide: shift remainder/quotient left, subtract divisor, restore if negative, set quotient bit.
  - SIGN at T+XLEN+1 applies negation:
    - Product negated if signA xor signB.
    - Quotient negated if signA xor signB.
    - Remainder takes sign of A.
  - DONE at T+XLEN+2.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- DONE:
  - done=1 for exactly one cycle; result and rd_out hold until the next acceptance.
  - Returns to IDLE unless start is high, which is a back-to-back acceptance.
- stall = (state==CALC) | (state==SIGN) | (start & (state==IDLE | state==DONE)).
  - stall is low in DONE, so EX advances and captures result.
- start while busy is ignored; the stall already freezes the instruction.
- flush:
  - Has priority over everything except reset.
  - From any state, go to IDLE next cycle with no done pulse; result is unchanged.
  - flush and start in the same cycle: start is ignored.
- Mid-operation reset: immediate IDLE, outputs cleared, no done.

Decomposition:
- Shared package rv_m_pkg holds:
  - funct3 localparams (F3_MUL … F3_REMU).
  - State encoding (S_IDLE=2'd0, S_CALC=1, S_SIGN=2, S_DONE=3).
  - M-extension funct7 constant 7'b0000001.
- One sub-module: muldiv_core_step, a combinational single-iteration multiply/divide step selected by an is_div input.
- The sequencer owns the FSM, counter, operand latching and sign fixup.

Test Plan:
- MUL 7×(-3), i.e. rs1=7, rs2=0xFFFFFFFD, start at cycle 0 -> stall high cycles 0..33, done at cycle 34, result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> result=0xFFFFFFFE. Same operands with MULH -> result=0x00000000. MULHSU (-1)×0xFFFFFFFF -> result=0xFFFFFFFF.
- DIV -20/6 -> result=0xFFFFFFFD (−3). REM -20/6 -> result=0xFFFFFFFE (−2). DIVU 100/7 -> result=14. REMU 100/7 -> result=2.
- DIV 5/0 -> done at cycle 1, result=0xFFFFFFFF. REMU 5/0 -> result=5. DIV 0x80000000/0xFFFFFFFF -> result=0x80000000, done at cycle 1.
- Start DIVU, assert flush at cycle 10 -> state IDLE at cycle 11, stall low, no done pulse ever, result unchanged.
- Back-to-back: start held in DONE cycle with new rd_in=9 -> new operation accepted, done again XLEN+2 cycles later, rd_out=9. Async reset asserted mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/rv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding and small decode helpers on funct3.
package rv_m_pkg;

   localparam logic [6:0] M_FUNCT7  = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Divide/remainder group is the upper half of the funct3 space.
   function automatic logic f3_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   // rs1 is signed for MULH, MULHSU, DIV and REM.
   function automatic logic f3_a_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
         default:                            s = 1'b0;
      endcase
      return s;
   endfunction

   // rs2 is signed for MULH, DIV and REM only.
   function automatic logic f3_b_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         F3_MULH, F3_DIV, F3_REM: s = 1'b1;
         default:                 s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One iteration of the radix-2 unsigned shift-add multiply or restoring
// divide. For multiply {hi,lo} is the product register with the multiplier in
// lo; for divide hi is the partial remainder and lo shifts dividend out and
// quotient bits in.
module muldiv_core_step #(
   parameter int XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi_in,
   input  logic [XLEN-1:0] lo_in,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] hi_out,
   output logic [XLEN-1:0] lo_out
);

   logic [XLEN:0]   sum_s;
   logic [XLEN:0]   shifted_s;
   logic [XLEN-1:0] diff_s;
   logic            neg_s;

   // Single multiply or divide step; the trial subtraction only needs the low
   // XLEN bits because a non-negative difference is always below the divisor.
   always_comb begin
      sum_s     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      shifted_s = {hi_in, lo_in[XLEN-1]};
      neg_s     = (shifted_s < {1'b0, operand});
      diff_s    = shifted_s[XLEN-1:0] - operand;
      if (is_div) begin
         lo_out = {lo_in[XLEN-2:0], ~neg_s};
         if (neg_s) begin
            hi_out = shifted_s[XLEN-1:0];
         end else begin
            hi_out = diff_s;
         end
      end else begin
         hi_out = sum_s[XLEN:1];
         lo_out = {sum_s[0], lo_in[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the Execute stage. Operands
// are reduced to magnitudes at acceptance, iterated XLEN times through
// muldiv_core_step, then sign-corrected in one extra cycle. Divide-by-zero and
// signed overflow bypass the iteration and complete the next cycle.
module muldiv_sequencer
   import rv_m_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   state_t            state_r, next_state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [2:0]        f3_r;
   logic [4:0]        rd_r;
   logic              sign_a_r, sign_b_r;
   logic [XLEN-1:0]   operand_r, hi_r, lo_r;
   logic [XLEN-1:0]   result_r;
   logic [4:0]        rd_out_r;

   logic              accept_s;
   logic              sign_a_s, sign_b_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s;
   logic              special_s;
   logic [XLEN-1:0]   special_val_s;
   logic [XLEN-1:0]   step_hi_s, step_lo_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_s;

   // Operand magnitudes and the one-cycle corner cases, evaluated on the raw inputs.
   always_comb begin
      sign_a_s      = f3_a_signed(funct3) & rs1_data[XLEN-1];
      sign_b_s      = f3_b_signed(funct3) & rs2_data[XLEN-1];
      mag_a_s       = sign_a_s ? (~rs1_data + 1'b1) : rs1_data;
      mag_b_s       = sign_b_s ? (~rs2_data + 1'b1) : rs2_data;
      special_s     = 1'b0;
      special_val_s = {XLEN{1'b0}};
      if (f3_is_div(funct3) && (rs2_data == {XLEN{1'b0}})) begin
         special_s     = 1'b1;
         special_val_s = funct3[1] ? rs1_data : ALL_ONES;
      end else if (f3_b_signed(funct3) && f3_is_div(funct3) &&
                   (rs1_data == INT_MIN) && (rs2_data == ALL_ONES)) begin
         special_s     = 1'b1;
         special_val_s = funct3[1] ? {XLEN{1'b0}} : INT_MIN;
      end else begin
         special_s     = 1'b0;
         special_val_s = {XLEN{1'b0}};
      end
   end

   muldiv_core_step #(.XLEN(XLEN)) u_step (
      .is_div  (f3_is_div(f3_r)),
      .hi_in   (hi_r),
      .lo_in   (lo_r),
      .operand (operand_r),
      .hi_out  (step_hi_s),
      .lo_out  (step_lo_s)
   );

   // Sign correction of the unsigned product or quotient/remainder.
   always_comb begin
      prod_s = {hi_r, lo_r};
      if (sign_a_r ^ sign_b_r) begin
         prod_s = ~{hi_r, lo_r} + 1'b1;
         quo_s  = ~lo_r + 1'b1;
      end else begin
         quo_s  = lo_r;
      end
      if (sign_a_r) begin
         rem_s = ~hi_r + 1'b1;
      end else begin
         rem_s = hi_r;
      end
      if (f3_is_div(f3_r)) begin
         fix_s = f3_r[1] ? rem_s : quo_s;
      end else if (f3_r == F3_MUL) begin
         fix_s = prod_s[XLEN-1:0];
      end else begin
         fix_s = prod_s[2*XLEN-1:XLEN];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; flush overrides acceptance and iteration.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      if (flush) begin
         next_state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start) begin
                  accept_s     = 1'b1;
                  next_state_s = special_s ? S_DONE : S_CALC;
               end else begin
                  next_state_s = S_IDLE;
               end
            end
            S_CALC: begin
               if (cnt_r == CNT_LAST) begin
                  next_state_s = S_SIGN;
               end else begin
                  next_state_s = S_CALC;
               end
            end
            S_SIGN:  next_state_s = S_DONE;
            default: next_state_s = S_IDLE;
         endcase
      end
   end

   // Operand latching, iteration and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= {CNT_W{1'b0}};
         f3_r      <= 3'b000;
         rd_r      <= 5'd0;
         sign_a_r  <= 1'b0;
         sign_b_r  <= 1'b0;
         operand_r <= {XLEN{1'b0}};
         hi_r      <= {XLEN{1'b0}};
         lo_r      <= {XLEN{1'b0}};
         result_r  <= {XLEN{1'b0}};
         rd_out_r  <= 5'd0;
      end else if (flush) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         cnt_r    <= {CNT_W{1'b0}};
         f3_r     <= funct3;
         rd_r     <= rd_in;
         sign_a_r <= sign_a_s;
         sign_b_r <= sign_b_s;
         hi_r     <= {XLEN{1'b0}};
         if (f3_is_div(funct3)) begin
            operand_r <= mag_b_s;
            lo_r      <= mag_a_s;
         end else begin
            operand_r <= mag_a_s;
            lo_r      <= mag_b_s;
         end
         if (special_s) begin
            result_r <= special_val_s;
            rd_out_r <= rd_in;
         end
      end else if (state_r == S_CALC) begin
         hi_r  <= step_hi_s;
         lo_r  <= step_lo_s;
         cnt_r <= cnt_r + 1'b1;
      end else if (state_r == S_SIGN) begin
         cnt_r    <= {CNT_W{1'b0}};
         result_r <= fix_s;
         rd_out_r <= rd_r;
      end
   end

   assign busy   = (state_r == S_CALC) | (state_r == S_SIGN);
   assign done   = (state_r == S_DONE);
   assign stall  = busy | (start & ((state_r == S_IDLE) | (state_r == S_DONE)));
   assign result = result_r;
   assign rd_out = rd_out_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver pushes the expected
// result, tag and completion cycle for each accepted operation; a monitor
// pops and compares whenever done is seen.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_in;
   logic        flush;
   logic        stall, busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[13];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   muldiv_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_in    (rd_in),
      .flush    (flush),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .rd_out   (rd_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 with empty scoreboard (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Issue one operation and walk to its completion cycle.
   task automatic run_op(input vec_t v);
      int t;
      exp_t e;
      @(negedge clk);
      start = 1'b1; funct3 = v.f3; rs1_data = v.a; rs2_data = v.b; rd_in = v.rd;
      t = cyc;
      #1;
      check("stall_at_start", {31'd0, stall}, 32'd1);
      e.res = v.exp; e.rd = v.rd; e.cyc = t + v.lat;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      if (v.lat > 1) begin
         while (cyc < t + v.lat - 1) @(negedge clk);
         check("stall_last_busy", {31'd0, stall}, 32'd1);
         check("busy_last", {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      #1;
      check("stall_in_done", {31'd0, stall}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      exp_t e;
      logic [31:0] last_res;
      vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34};
      vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34};
      vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 34};
      vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34};
      vecs[4]  = '{3'b100, 32'hFFFFFFEC, 32'h00000006, 5'd5,  32'hFFFFFFFD, 34};
      vecs[5]  = '{3'b110, 32'hFFFFFFEC, 32'h00000006, 5'd6,  32'hFFFFFFFE, 34};
      vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       34};
      vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        34};
      vecs[8]  = '{3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1};
      vecs[9]  = '{3'b111, 32'd5,        32'd0,        5'd11, 32'd5,        1};
      vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1};
      vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1};
      vecs[12] = '{3'b000, 32'h12345678, 32'h00000010, 5'd31, 32'h23456780, 34};

      rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; rs1_data = 32'd0;
      rs2_data = 32'd0; rd_in = 5'd0; flush = 1'b0;
      #3;
      check("reset_busy",   {31'd0, busy},  32'd0);
      check("reset_done",   {31'd0, done},  32'd0);
      check("reset_stall",  {31'd0, stall}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_rd_out", {27'd0, rd_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_op(vecs[i]);

      // Back-to-back: second start held during the DONE cycle of the first.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3;
      t = cyc;
      e.res = 32'd14; e.rd = 5'd3; e.cyc = t + 34;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      while (cyc < t + 34) @(negedge clk);
      start = 1'b1; funct3 = 3'b100; rs1_data = 32'hFFFFFFEC; rs2_data = 32'd6; rd_in = 5'd9;
      #1;
      check("b2b_stall_in_done", {31'd0, stall}, 32'd1);
      e.res = 32'hFFFFFFFD; e.rd = 5'd9; e.cyc = t + 68;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      while (cyc < t + 68) @(negedge clk);
      last_res = 32'hFFFFFFFD;

      // Flush mid-divide: no completion and result held.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd4;
      t = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < t + 10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_busy",   {31'd0, busy},  32'd0);
      check("flush_stall",  {31'd0, stall}, 32'd0);
      check("flush_result", result, last_res);
      check("flush_rd_out", {27'd0, rd_out}, 32'd9);
      repeat (40) @(negedge clk);
      check("flush_result_later", result, last_res);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5; rd_in = 5'd20;
      t = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < t + 5) @(negedge clk);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_busy",   {31'd0, busy},  32'd0);
      check("midreset_done",   {31'd0, done},  32'd0);
      check("midreset_stall",  {31'd0, stall}, 32'd0);
      check("midreset_result", result, 32'd0);
      check("midreset_rd_out", {27'd0, rd_out}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(vecs[12]);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
